// File: rtl/obi_one_to_n_demux.sv
// OBI 1-master to N-slave demultiplexer with in-order response routing through an
// outstanding-target FIFO; unmapped addresses are answered by an internal error responder.

package obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_one_to_n_demux
    import obi_pkg::*;
#(
    parameter int          NSLAVE          = 3,
    parameter int          SEL_LSB         = 16,
    parameter int          SEL_W           = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] ERR_RDATA       = 32'hBADACCE5
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  obi_req_t                             master_req_i,
    output obi_resp_t                            master_resp_o,
    output obi_req_t                             slave_req_o  [NSLAVE],
    input  obi_resp_t                            slave_resp_i [NSLAVE],
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
    localparam int TGT_W = $clog2(NSLAVE + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [TGT_W-1:0] tgt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    localparam tgt_t ERR_TGT = TGT_W'(NSLAVE);

    tgt_t             fifo_q [MAX_OUTSTANDING];
    tgt_t             fifo_d [MAX_OUTSTANDING];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    tgt_t             last_tgt_q, last_tgt_d;
    logic             err_pending_q, err_pending_d;

    logic [SEL_W-1:0] sel;
    logic             mapped;
    tgt_t             tgt;
    tgt_t             head;
    logic             full, empty, allow, slave_gnt, push, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sel    = master_req_i.addr[SEL_LSB +: SEL_W];
        mapped = (int'(sel) < NSLAVE);
        tgt    = mapped ? TGT_W'(sel) : ERR_TGT;
        full   = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty  = (count_q == '0);
        // Only a same-target request may join in-flight traffic; switching waits for drain.
        allow  = !rst_i && !full && (empty || tgt == last_tgt_q);

        slave_gnt = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            slave_req_o[i]     = master_req_i;
            slave_req_o[i].req = allow && master_req_i.req && (tgt == TGT_W'(i));
            if (tgt == TGT_W'(i)) slave_gnt = slave_resp_i[i].gnt;
        end

        master_resp_o.gnt = allow && (mapped ? slave_gnt : master_req_i.req);
        push              = master_req_i.req && master_resp_o.gnt;

        head                 = fifo_q[rd_ptr_q];
        master_resp_o.rvalid = 1'b0;
        master_resp_o.rdata  = '0;
        if (!rst_i && !empty) begin
            if (head == ERR_TGT) begin
                master_resp_o.rvalid = err_pending_q;
                master_resp_o.rdata  = err_pending_q ? ERR_RDATA : '0;
            end else begin
                for (int i = 0; i < NSLAVE; i++) begin
                    if (head == TGT_W'(i) && slave_resp_i[i].rvalid) begin
                        master_resp_o.rvalid = 1'b1;
                        master_resp_o.rdata  = slave_resp_i[i].rdata;
                    end
                end
            end
        end
        pop = master_resp_o.rvalid;

        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_d   = fifo_q;
        if (push) fifo_d[wr_ptr_q] = tgt;
        last_tgt_d    = push ? tgt : last_tgt_q;
        err_pending_d = push && !mapped;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_tgt_q    <= '0;
            err_pending_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_tgt_q    <= last_tgt_d;
            err_pending_q <= err_pending_d;
        end
    end

    // NOTE: FIFO storage is not reset; its contents are only read while the count is non-zero.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    assign outstanding_o = rst_i ? '0 : count_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full))
                else $error("push into full outstanding FIFO");
            for (int i = 0; i < NSLAVE; i++) begin
                assert (!slave_resp_i[i].rvalid || (!empty && head == TGT_W'(i)))
                    else $warning("stray rvalid from slave %0d dropped", i);
            end
        end
    end
`endif
endmodule
